dmem_responder: RTL and testbench

Memory-side responder for the load/store unit's data-memory request channel. It accepts one request at a time: a write with byte strobes, or a full 64-bit read. It services the request against an internal word-addressed array and returns a response after a fixed, parameterised latency. It sits below the LSU in place of an external data RAM and gives the pipeline a deterministic memory for simulation and bring-up.

---
 rtl/dmem_responder.sv | 99 +++++++++
 tb/tb_dmem_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Deterministic data-memory responder for the LSU request channel: one request
// in flight, 64-bit word array, byte-strobed writes, fixed response latency.
module dmem_responder #(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [7:0]  req_wstrb,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = $clog2(LATENCY + 1);
    localparam logic [63:0] LIMIT = BASE + (64'(DEPTH) << 3);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [63:0]   mem [DEPTH];
    logic          in_range;
    logic [AW-1:0] idx;
    logic          accept;

    assign in_range = (req_addr >= BASE) && (req_addr < LIMIT);
    assign idx      = AW'((req_addr - BASE) >> 3);
    assign accept   = req_valid && req_ready && !reset;

    // NOTE: the array has no reset; clearing it would need a multi-cycle sweep
    // and bring-up software must not rely on initial contents anyway.
    always_ff @(posedge clock) begin
        if (accept && req_wen && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: every register here uses <= so all of them see pre-edge values,
    // which keeps the read-capture and state update order-independent.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        resp_err   <= !in_range;
                        resp_rdata <= (in_range && !req_wen) ? mem[idx] : '0;
                        count      <= CW'(LATENCY - 1);
                        req_ready  <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    // Response held stable until the requester takes it.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: three instances
// (LATENCY 2, 1, 5) checked against an associative-array memory model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          NDUT  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_wen    [NDUT];
    logic [7:0]  req_wstrb  [NDUT];
    logic [63:0] req_addr   [NDUT];
    logic [63:0] req_wdata  [NDUT];
    logic        resp_valid [NDUT];
    logic        resp_ready [NDUT];
    logic [63:0] resp_rdata [NDUT];
    logic        resp_err   [NDUT];

    int tests = 0;
    int fails = 0;
    logic [63:0] model [int];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .DEPTH(DEPTH), .BASE(BASE),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 5))
        ) dut (
            .clock(clock), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_wen(req_wen[g]), .req_wstrb(req_wstrb[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
        );
    end

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int key(input int d, input int w);
        return d * int'(DEPTH) + w;
    endfunction

    // One full request/response. All tasks start and end at a negedge.
    task automatic transact(input int d, input logic wen, input logic [63:0] addr,
                            input logic [7:0] wstrb, input logic [63:0] wdata,
                            input int stall, input string name,
                            output logic [63:0] got_rdata, output logic got_err);
        logic [63:0] exp_rdata, cur;
        logic        exp_err, in_range;
        int          w, k;
        in_range  = (addr >= BASE) && (addr < BASE + 64'(DEPTH) * 8);
        w         = in_range ? int'((addr - BASE) / 8) : 0;
        exp_err   = !in_range;
        exp_rdata = (in_range && !wen) ? model[key(d, w)] : 64'h0;
        got_rdata = 'x;
        got_err   = 'x;
        k = 0;
        while (req_ready[d] !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        tests++;
        if (req_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready[d]);
            return;
        end
        req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
        req_wstrb[d] = wstrb; req_wdata[d] = wdata; resp_ready[d] = (stall == 0);
        @(negedge clock);
        req_valid[d] = 1'b0; req_wen[d] = 1'($urandom); req_addr[d] = {$urandom, $urandom};
        req_wstrb[d] = 8'($urandom); req_wdata[d] = {$urandom, $urandom};
        if (in_range && wen) begin
            cur = model.exists(key(d, w)) ? model[key(d, w)] : 64'h0;
            for (int i = 0; i < 8; i++) if (wstrb[i]) cur[8*i +: 8] = wdata[8*i +: 8];
            model[key(d, w)] = cur;
        end
        k = 1;
        while (resp_valid[d] !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        tests++;
        if (k != lat_of(d)) begin
            fails++;
            $display("FAIL %s latency: resp_valid after %0d cycles, required %0d", name, k, lat_of(d));
        end
        got_rdata = resp_rdata[d];
        got_err   = resp_err[d];
        tests++;
        if (resp_rdata[d] !== exp_rdata || resp_err[d] !== exp_err || req_ready[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s resp: rdata=%h err=%b req_ready=%b, required rdata=%h err=%b req_ready=0",
                     name, resp_rdata[d], resp_err[d], req_ready[d], exp_rdata, exp_err);
        end
        for (int c = 0; c < stall; c++) begin
            if (c == stall / 2) begin
                req_valid[d] = 1'b1; req_wen[d] = 1'b1; req_addr[d] = addr;
                req_wstrb[d] = 8'hFF; req_wdata[d] = ~exp_rdata;
            end
            @(negedge clock);
            req_valid[d] = 1'b0;
            tests++;
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== exp_rdata ||
                resp_err[d] !== exp_err || req_ready[d] !== 1'b0) begin
                fails++;
                $display("FAIL %s stall%0d: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                         name, c, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d],
                         exp_rdata, exp_err);
            end
        end
        resp_ready[d] = 1'b1;
        @(negedge clock);
        tests++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 ||
            resp_rdata[d] !== 64'h0 || resp_err[d] !== 1'b0) begin
            fails++;
            $display("FAIL %s release: valid=%b req_ready=%b rdata=%h err=%b, required 0 1 0 0",
                     name, resp_valid[d], req_ready[d], resp_rdata[d], resp_err[d]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int d = 0; d < NDUT; d++) begin
            tests++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 64'h0 || resp_err[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_dut%0d: req_ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic init_words(input int d);
        int          words [8] = '{0, 1, 2, 3, 5, 9, 4094, 4095};
        logic [63:0] r;
        logic        e;
        foreach (words[i])
            transact(d, 1'b1, BASE + 64'(words[i]) * 8, 8'hFF, {$urandom, $urandom}, 0, "init", r, e);
    endtask

    task automatic test_merge;
        logic [63:0] r;
        logic        e;
        transact(0, 1'b1, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 0, "merge_w1", r, e);
        transact(0, 1'b1, 64'h8000_0013, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 0, "merge_w2", r, e);
        transact(0, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, "merge_rd", r, e);
        tests++;
        if (r !== 64'h1122_3344_AAAA_AAAA || e !== 1'b0) begin
            fails++;
            $display("FAIL merge_value: rdata=%h err=%b, required 11223344aaaaaaaa 0", r, e);
        end
    endtask

    task automatic test_out_of_range;
        logic [63:0] r;
        logic        e;
        transact(0, 1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0, 0, "oor_rd_low", r, e);
        transact(0, 1'b1, 64'h8000_8000, 8'hFF, {$urandom, $urandom}, 0, "oor_wr_high", r, e);
        transact(0, 1'b0, 64'h8000_0000, 8'h00, 64'h0, 0, "oor_word0", r, e);
        transact(0, 1'b0, 64'h8000_7FF8, 8'h00, 64'h0, 0, "last_word", r, e);
    endtask

    task automatic test_zero_strobe;
        logic [63:0] r;
        logic        e;
        transact(0, 1'b1, BASE + 9 * 8, 8'h00, {$urandom, $urandom}, 0, "zero_strobe_wr", r, e);
        transact(0, 1'b0, BASE + 9 * 8, 8'h00, 64'h0, 0, "zero_strobe_rd", r, e);
    endtask

    task automatic test_backpressure;
        logic [63:0] r;
        logic        e;
        transact(0, 1'b0, BASE + 5 * 8, 8'h00, 64'h0, 5, "stall_rd", r, e);
        transact(0, 1'b0, BASE + 5 * 8, 8'h00, 64'h0, 0, "stall_reread", r, e);
    endtask

    task automatic test_reset_mid_op;
        logic [63:0] r, data;
        logic        e;
        for (int op = 0; op < 2; op++) begin
            data = {$urandom, $urandom};
            req_valid[0] = 1'b1; req_wen[0] = 1'(op); req_addr[0] = BASE + 3 * 8;
            req_wstrb[0] = 8'hFF; req_wdata[0] = data; resp_ready[0] = 1'b1;
            @(negedge clock);
            req_valid[0] = 1'b0;
            if (op == 1) model[key(0, 3)] = data;
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            tests++;
            if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_op%0d: req_ready=%b valid=%b, required 1 0",
                         op, req_ready[0], resp_valid[0]);
            end
            for (int c = 0; c < 6; c++) begin
                @(negedge clock);
                tests++;
                if (resp_valid[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_stale%0d: resp_valid=%b required 0", op, resp_valid[0]);
                end
            end
        end
        transact(0, 1'b0, BASE + 3 * 8, 8'h00, 64'h0, 0, "reset_commit_rd", r, e);
    endtask

    task automatic test_random;
        int          words [8] = '{0, 1, 2, 3, 5, 9, 4094, 4095};
        logic [63:0] r, addr;
        logic        e;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       addr = BASE - 64'($urandom_range(1, 100)) * 8;
                1:       addr = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 1000)) * 8;
                default: addr = BASE + 64'(words[$urandom_range(0, 7)]) * 8;
            endcase
            addr = addr | 64'($urandom_range(0, 7));
            transact(0, 1'($urandom), addr, 8'($urandom), {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, "random", r, e);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int last = -1;
        int n    = 0;
        req_valid[d] = 1'b1; req_wen[d] = 1'b0; req_addr[d] = BASE;
        req_wstrb[d] = 8'h00; req_wdata[d] = 64'h0; resp_ready[d] = 1'b1;
        for (int cyc = 0; cyc < 4 * (lat_of(d) + 1) + 2; cyc++) begin
            if (req_ready[d] === 1'b1) begin
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != lat_of(d) + 1) begin
                        fails++;
                        $display("FAIL b2b_dut%0d gap: %0d cycles, required %0d", d, cyc - last, lat_of(d) + 1);
                    end
                end
                last = cyc;
                n++;
            end
            @(negedge clock);
        end
        req_valid[d] = 1'b0;
        tests++;
        if (n < 3) begin
            fails++;
            $display("FAIL b2b_dut%0d accepts: %0d, required at least 3", d, n);
        end
        repeat (lat_of(d) + 2) @(negedge clock);
    endtask

    task automatic test_latency_sweep;
        logic [63:0] r;
        logic        e;
        for (int d = 1; d < NDUT; d++) begin
            init_words(d);
            transact(d, 1'b0, BASE, 8'h00, 64'h0, 0, "sweep_rd", r, e);
            transact(d, 1'b1, BASE + 2 * 8, 8'h3C, {$urandom, $urandom}, 0, "sweep_wr", r, e);
            transact(d, 1'b0, BASE + 2 * 8, 8'h00, 64'h0, 0, "sweep_rd2", r, e);
            test_back_to_back(d);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_wstrb[d] = 8'h00;
            req_addr[d] = 64'h0; req_wdata[d] = 64'h0; resp_ready[d] = 1'b1;
        end
        @(negedge clock);
        test_reset();
        init_words(0);
        test_merge();
        test_out_of_range();
        test_zero_strobe();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_back_to_back(0);
        test_latency_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
